// File: rtl/count_seq_monitor_if.sv
// Bus bundle for count_seq_monitor: code sample stream in, lock status and counters out.
// master drives the sample stream; slave is the monitor.
interface count_seq_monitor_if #(
   parameter int ERR_W  = 8,
   parameter int WRAP_W = 16
);
   logic              in_valid;
   logic [2:0]        y_in;
   logic              clr;
   logic [1:0]        phase;
   logic              locked;
   logic              seq_err;
   logic              err_sticky;
   logic [ERR_W-1:0]  err_cnt;
   logic [WRAP_W-1:0] wrap_cnt;
   logic              timeout;

   modport master (
      output in_valid, y_in, clr,
      input  phase, locked, seq_err, err_sticky, err_cnt, wrap_cnt, timeout
   );

   modport slave (
      input  in_valid, y_in, clr,
      output phase, locked, seq_err, err_sticky, err_cnt, wrap_cnt, timeout
   );
endinterface

// File: rtl/count_seq_monitor.sv
// Lock-on checker for the 2-bit counter code stream 000->011->101->111.
// Optional LOCKED idle timeout enabled by defining COUNT_SEQ_MON_TIMEOUT_EN.
module count_seq_monitor #(
   parameter int LOCK_N  = 3,
   parameter int ERR_W   = 8,
   parameter int WRAP_W  = 16,
   parameter int TIMEOUT = 8
) (
   input  logic                clk,
   input  logic                rst,
   count_seq_monitor_if.slave  mon
);

   if (LOCK_N < 1 || LOCK_N > 15) begin : g_chk_lock
      $error("LOCK_N must be in 1..15");
   end
   if (TIMEOUT < 1) begin : g_chk_to
      $error("TIMEOUT must be >= 1");
   end

   typedef enum logic [1:0] {UNLOCKED, LOCKING, LOCKED} state_t;

   state_t            state_q, state_d;
   logic [1:0]        prev_q, prev_d;
   logic [3:0]        good_q, good_d;
   logic [1:0]        phase_q, phase_d;
   logic              locked_q, locked_d;
   logic              seq_err_q, seq_err_d;
   logic              sticky_q, sticky_d;
   logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
   logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
   logic              timeout_q, timeout_d;

   logic              code_legal;
   logic [1:0]        code_ph;
   logic              is_succ;
   logic              err_ev, wrap_ev, to_ev;

`ifdef COUNT_SEQ_MON_TIMEOUT_EN
   localparam int IDLE_W = $clog2(TIMEOUT + 1);
   logic [IDLE_W-1:0] idle_q, idle_d;
`endif

   always_comb begin
      code_legal = 1'b1;
      code_ph    = '0;
      case (mon.y_in)
         3'b000:  code_ph = 2'd0;
         3'b011:  code_ph = 2'd1;
         3'b101:  code_ph = 2'd2;
         3'b111:  code_ph = 2'd3;
         default: code_legal = 1'b0;
      endcase
   end

   assign is_succ = code_legal && (code_ph == prev_q + 2'd1);

   // Next-state: FSM, lock tracking and the events that feed the output registers.
   always_comb begin
      state_d = state_q;
      prev_d  = prev_q;
      good_d  = good_q;
      err_ev  = 1'b0;
      wrap_ev = 1'b0;
      to_ev   = 1'b0;
`ifdef COUNT_SEQ_MON_TIMEOUT_EN
      idle_d  = '0;
`endif
      if (mon.in_valid) begin
         case (state_q)
            UNLOCKED: begin
               if (code_legal) begin
                  prev_d  = code_ph;
                  good_d  = '0;
                  state_d = LOCKING;
               end
            end
            LOCKING: begin
               if (!code_legal) begin
                  state_d = UNLOCKED;
               end else if (is_succ) begin
                  prev_d = code_ph;
                  good_d = good_q + 4'd1;
                  if (int'(good_d) >= LOCK_N) state_d = LOCKED;
               end else begin
                  prev_d = code_ph;
                  good_d = '0;
               end
            end
            LOCKED: begin
               if (is_succ) begin
                  prev_d  = code_ph;
                  wrap_ev = (prev_q == 2'd3);
               end else begin
                  err_ev  = 1'b1;
                  good_d  = '0;
                  state_d = UNLOCKED;
               end
            end
            default: state_d = UNLOCKED;
         endcase
      end
`ifdef COUNT_SEQ_MON_TIMEOUT_EN
      else if (state_q == LOCKED) begin
         idle_d = idle_q + IDLE_W'(1);
         if (int'(idle_d) == TIMEOUT) begin
            to_ev   = 1'b1;
            idle_d  = '0;
            good_d  = '0;
            state_d = UNLOCKED;
         end
      end
`endif
   end

   // clr takes priority over any same-cycle increment or sticky set.
   always_comb begin
      phase_d    = (mon.in_valid && code_legal) ? code_ph : phase_q;
      locked_d   = (state_d == LOCKED);
      seq_err_d  = err_ev;
      timeout_d  = to_ev;
      sticky_d   = sticky_q | err_ev;
      err_cnt_d  = (err_ev && (err_cnt_q != '1)) ? err_cnt_q + ERR_W'(1) : err_cnt_q;
      wrap_cnt_d = wrap_ev ? wrap_cnt_q + WRAP_W'(1) : wrap_cnt_q;
      if (mon.clr) begin
         sticky_d   = 1'b0;
         err_cnt_d  = '0;
         wrap_cnt_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= UNLOCKED;
         prev_q     <= '0;
         good_q     <= '0;
         phase_q    <= '0;
         locked_q   <= 1'b0;
         seq_err_q  <= 1'b0;
         sticky_q   <= 1'b0;
         err_cnt_q  <= '0;
         wrap_cnt_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         prev_q     <= prev_d;
         good_q     <= good_d;
         phase_q    <= phase_d;
         locked_q   <= locked_d;
         seq_err_q  <= seq_err_d;
         sticky_q   <= sticky_d;
         err_cnt_q  <= err_cnt_d;
         wrap_cnt_q <= wrap_cnt_d;
         timeout_q  <= timeout_d;
      end
   end

`ifdef COUNT_SEQ_MON_TIMEOUT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) idle_q <= '0;
      else     idle_q <= idle_d;
   end
`endif

   assign mon.phase      = phase_q;
   assign mon.locked     = locked_q;
   assign mon.seq_err    = seq_err_q;
   assign mon.err_sticky = sticky_q;
   assign mon.err_cnt    = err_cnt_q;
   assign mon.wrap_cnt   = wrap_cnt_q;
   assign mon.timeout    = timeout_q;

endmodule

// File: tb/tb_count_seq_monitor.sv
// Scoreboard bench for count_seq_monitor: a behavioural model queues the expected
// outputs for every driven sample; each scenario task drains and compares them.
module tb_count_seq_monitor;
   localparam int LOCK_N  = 3;
   localparam int ERR_W   = 2;
   localparam int WRAP_W  = 3;
   localparam int TIMEOUT = 8;
   localparam int UNL = 0, LKG = 1, LKD = 2;

   typedef struct packed {
      logic [1:0]        phase;
      logic              locked;
      logic              seq_err;
      logic              err_sticky;
      logic [ERR_W-1:0]  err_cnt;
      logic [WRAP_W-1:0] wrap_cnt;
      logic              timeout;
   } out_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   count_seq_monitor_if #(.ERR_W(ERR_W), .WRAP_W(WRAP_W)) bus ();

   count_seq_monitor #(
      .LOCK_N(LOCK_N), .ERR_W(ERR_W), .WRAP_W(WRAP_W), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .mon(bus)
   );

   out_t exp_q[$];
   out_t obs_q[$];
   int   n_run  = 0;
   int   n_fail = 0;

   int         m_state, m_prev, m_good, m_idle, m_err, m_wrap;
   logic [1:0] m_phase;
   logic       m_sticky;

   function automatic out_t observe();
      out_t o;
      o.phase      = bus.phase;
      o.locked     = bus.locked;
      o.seq_err    = bus.seq_err;
      o.err_sticky = bus.err_sticky;
      o.err_cnt    = bus.err_cnt;
      o.wrap_cnt   = bus.wrap_cnt;
      o.timeout    = bus.timeout;
      return o;
   endfunction

   task automatic model_reset();
      m_state = UNL; m_prev = 0; m_good = 0; m_idle = 0;
      m_err = 0; m_wrap = 0; m_phase = 2'd0; m_sticky = 1'b0;
   endtask

   // Drive one sample, queue what the monitor must show after this edge, capture it.
   task automatic step(input logic v, input logic [2:0] y, input logic c);
      out_t e;
      bit   legal, se, to, wr;
      int   ph;
      se = 0; to = 0; wr = 0;
      bus.in_valid = v; bus.y_in = y; bus.clr = c;
      legal = 1;
      case (y)
         3'b000:  ph = 0;
         3'b011:  ph = 1;
         3'b101:  ph = 2;
         3'b111:  ph = 3;
         default: begin legal = 0; ph = 0; end
      endcase
`ifdef COUNT_SEQ_MON_TIMEOUT_EN
      if (!v && m_state == LKD) begin
         m_idle++;
         if (m_idle == TIMEOUT) begin
            to = 1; m_idle = 0; m_good = 0; m_state = UNL;
         end
      end else m_idle = 0;
`endif
      if (v) begin
         if (m_state == UNL) begin
            if (legal) begin m_prev = ph; m_good = 0; m_state = LKG; end
         end else if (m_state == LKG) begin
            if (!legal) m_state = UNL;
            else if (ph == (m_prev + 1) % 4) begin
               m_good++; m_prev = ph;
               if (m_good == LOCK_N) m_state = LKD;
            end else begin
               m_prev = ph; m_good = 0;
            end
         end else begin
            if (legal && ph == (m_prev + 1) % 4) begin
               wr = (m_prev == 3); m_prev = ph;
            end else begin
               se = 1; m_good = 0; m_state = UNL;
            end
         end
         if (legal) m_phase = 2'(ph);
      end
      if (se) begin
         m_sticky = 1'b1;
         if (m_err < (1 << ERR_W) - 1) m_err++;
      end
      if (wr) m_wrap = (m_wrap + 1) % (1 << WRAP_W);
      if (c) begin m_sticky = 1'b0; m_err = 0; m_wrap = 0; end
      e.phase = m_phase; e.locked = (m_state == LKD); e.seq_err = se;
      e.err_sticky = m_sticky; e.err_cnt = ERR_W'(m_err);
      e.wrap_cnt = WRAP_W'(m_wrap); e.timeout = to;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      obs_q.push_back(observe());
   endtask

   task automatic relock();
      step(1, 3'b000, 0); step(1, 3'b011, 0); step(1, 3'b101, 0); step(1, 3'b111, 0);
   endtask

   task automatic test_reset();
      out_t e, o;
      bus.in_valid = 1'b0; bus.y_in = 3'b000; bus.clr = 1'b0;
      rst = 1'b1;
      #2;
      n_run++;
      if (observe() !== out_t'(0)) begin
         n_fail++; $display("FAIL reset_state: outputs %h, expected 0", observe());
      end
      bus.in_valid = 1'b1; bus.y_in = 3'b011;
      @(posedge clk); #1;
      n_run++;
      if (bus.phase !== 2'd0 || bus.locked !== 1'b0) begin
         n_fail++; $display("FAIL reset_hold: phase=%0d locked=%b, expected 0/0", bus.phase, bus.locked);
      end
      bus.in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_run++;
         if (o !== e) begin n_fail++; $display("FAIL reset_sb: outputs %h, expected %h", o, e); end
      end
   endtask

   task automatic test_lock();
      out_t e, o;
      step(1, 3'b000, 0); step(1, 3'b011, 0); step(1, 3'b101, 0);
      n_run++;
      if (bus.locked !== 1'b0) begin n_fail++; $display("FAIL lock_early: locked=%b, expected 0", bus.locked); end
      step(1, 3'b111, 0);
      n_run++;
      if (bus.locked !== 1'b1 || bus.phase !== 2'd3) begin
         n_fail++; $display("FAIL lock_done: locked=%b phase=%0d, expected 1/3", bus.locked, bus.phase);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_run++;
         if (o !== e) begin n_fail++; $display("FAIL lock_sb: outputs %h, expected %h", o, e); end
      end
   endtask

   task automatic test_wrap();
      out_t e, o;
      for (int i = 0; i < 3; i++) begin
         step(1, 3'b000, 0); step(1, 3'b011, 0); step(1, 3'b101, 0); step(1, 3'b111, 0);
      end
      step(1, 3'b000, 0);
      n_run++;
      if (bus.wrap_cnt !== WRAP_W'(4) || bus.err_cnt !== '0) begin
         n_fail++; $display("FAIL wrap_count: wrap=%0d err=%0d, expected 4/0", bus.wrap_cnt, bus.err_cnt);
      end
      for (int i = 0; i < 4; i++) begin
         step(1, 3'b011, 0); step(1, 3'b101, 0); step(1, 3'b111, 0); step(1, 3'b000, 0);
      end
      n_run++;
      if (bus.wrap_cnt !== '0) begin
         n_fail++; $display("FAIL wrap_rollover: wrap=%0d, expected 0", bus.wrap_cnt);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_run++;
         if (o !== e) begin n_fail++; $display("FAIL wrap_sb: outputs %h, expected %h", o, e); end
      end
   endtask

   task automatic test_error();
      out_t e, o;
      step(1, 3'b011, 0);
      step(1, 3'b111, 0);
      n_run++;
      if (bus.seq_err !== 1'b1 || bus.err_cnt !== ERR_W'(1) || bus.err_sticky !== 1'b1 || bus.locked !== 1'b0) begin
         n_fail++;
         $display("FAIL err_detect: seq_err=%b err=%0d sticky=%b locked=%b, expected 1/1/1/0",
                  bus.seq_err, bus.err_cnt, bus.err_sticky, bus.locked);
      end
      relock();
      n_run++;
      if (bus.locked !== 1'b1 || bus.err_sticky !== 1'b1 || bus.seq_err !== 1'b0) begin
         n_fail++; $display("FAIL err_relock: locked=%b sticky=%b seq_err=%b, expected 1/1/0",
                            bus.locked, bus.err_sticky, bus.seq_err);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_run++;
         if (o !== e) begin n_fail++; $display("FAIL err_sb: outputs %h, expected %h", o, e); end
      end
   endtask

   task automatic test_err_sat();
      out_t e, o;
      for (int i = 0; i < 4; i++) begin
         step(1, 3'b010, 0);
         relock();
      end
      n_run++;
      if (bus.err_cnt !== 2'd3 || bus.locked !== 1'b1) begin
         n_fail++; $display("FAIL err_saturate: err=%0d locked=%b, expected 3/1", bus.err_cnt, bus.locked);
      end
      step(1, 3'b010, 1);
      n_run++;
      if (bus.seq_err !== 1'b1 || bus.err_cnt !== '0 || bus.err_sticky !== 1'b0) begin
         n_fail++; $display("FAIL clr_priority: seq_err=%b err=%0d sticky=%b, expected 1/0/0",
                            bus.seq_err, bus.err_cnt, bus.err_sticky);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_run++;
         if (o !== e) begin n_fail++; $display("FAIL sat_sb: outputs %h, expected %h", o, e); end
      end
   endtask

   task automatic test_unlocked_illegal();
      out_t e, o;
      step(1, 3'b010, 0);
      n_run++;
      if (bus.seq_err !== 1'b0 || bus.locked !== 1'b0) begin
         n_fail++; $display("FAIL illegal_unlocked: seq_err=%b locked=%b, expected 0/0", bus.seq_err, bus.locked);
      end
      step(1, 3'b000, 0); step(1, 3'b011, 0); step(1, 3'b010, 0);
      n_run++;
      if (bus.seq_err !== 1'b0 || bus.phase !== 2'd1) begin
         n_fail++; $display("FAIL illegal_locking: seq_err=%b phase=%0d, expected 0/1", bus.seq_err, bus.phase);
      end
      step(1, 3'b000, 0); step(0, 3'b110, 0); step(0, 3'b000, 0);
      step(1, 3'b011, 0); step(0, 3'b111, 0);
      step(1, 3'b101, 0); step(0, 3'b000, 0); step(0, 3'b001, 0);
      step(1, 3'b111, 0);
      n_run++;
      if (bus.locked !== 1'b1 || bus.phase !== 2'd3) begin
         n_fail++; $display("FAIL gap_lock: locked=%b phase=%0d, expected 1/3", bus.locked, bus.phase);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_run++;
         if (o !== e) begin n_fail++; $display("FAIL illegal_sb: outputs %h, expected %h", o, e); end
      end
   endtask

   task automatic test_back_to_back();
      out_t e, o;
      step(1, 3'b000, 0);
      step(1, 3'b000, 0);
      n_run++;
      if (bus.seq_err !== 1'b1 || bus.err_cnt !== ERR_W'(1)) begin
         n_fail++; $display("FAIL repeat_err: seq_err=%b err=%0d, expected 1/1", bus.seq_err, bus.err_cnt);
      end
      step(1, 3'b011, 0);
      n_run++;
      if (bus.seq_err !== 1'b0) begin
         n_fail++; $display("FAIL err_pulse_width: seq_err=%b, expected 0", bus.seq_err);
      end
      step(1, 3'b111, 0); step(1, 3'b000, 0); step(1, 3'b011, 0);
      step(1, 3'b101, 0);
      n_run++;
      if (bus.locked !== 1'b1 || bus.phase !== 2'd2) begin
         n_fail++; $display("FAIL restart_lock: locked=%b phase=%0d, expected 1/2", bus.locked, bus.phase);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_run++;
         if (o !== e) begin n_fail++; $display("FAIL b2b_sb: outputs %h, expected %h", o, e); end
      end
   endtask

   task automatic test_timeout();
      out_t e, o;
      for (int i = 0; i < TIMEOUT; i++) step(0, 3'b000, 0);
`ifdef COUNT_SEQ_MON_TIMEOUT_EN
      n_run++;
      if (bus.timeout !== 1'b1 || bus.locked !== 1'b0 || bus.seq_err !== 1'b0) begin
         n_fail++; $display("FAIL timeout_fire: timeout=%b locked=%b seq_err=%b, expected 1/0/0",
                            bus.timeout, bus.locked, bus.seq_err);
      end
`else
      for (int i = 0; i < 12; i++) step(0, 3'b000, 0);
      n_run++;
      if (bus.timeout !== 1'b0 || bus.locked !== 1'b1) begin
         n_fail++; $display("FAIL timeout_off: timeout=%b locked=%b, expected 0/1", bus.timeout, bus.locked);
      end
`endif
      step(0, 3'b000, 0);
      step(1, 3'b111, 0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_run++;
         if (o !== e) begin n_fail++; $display("FAIL timeout_sb: outputs %h, expected %h", o, e); end
      end
   endtask

   task automatic test_rst_mid();
      out_t e, o;
      relock();
      #3 rst = 1'b1;
      #1;
      n_run++;
      if (observe() !== out_t'(0)) begin
         n_fail++; $display("FAIL async_reset: outputs %h, expected 0", observe());
      end
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      step(1, 3'b011, 0); step(1, 3'b101, 0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_run++;
         if (o !== e) begin n_fail++; $display("FAIL rst_mid_sb: outputs %h, expected %h", o, e); end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_lock();
      test_wrap();
      test_error();
      test_err_sat();
      test_unlocked_illegal();
      test_back_to_back();
      test_timeout();
      test_rst_mid();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
